// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program counter generator with optional return-address stack.
//
// Every clock the registered fetch address moves to its next value. The
// sources, highest priority first, are:
//   exc_req -> EXC_VEC, eret -> epc, stall -> hold, branch -> pc + offset,
//   jump -> jump_addr, otherwise pc + 4.
// exc_req and eret act as a flush, so they win over stall. All address
// arithmetic wraps modulo 2^WIDTH.
//
// fetch_err is a combinational decode of pc. It is 1 when pc is not
// word-aligned or lies outside [IMEM_LO, IMEM_HI]. It has no effect on how
// pc is sequenced.
//
// Optional feature (macro PC_GEN_RAS_EN): a circular return-address stack
// with RAS_DEPTH entries. When the stack is full, a push overwrites the
// oldest entry and sets the sticky ras_ovf. When the macro is not defined,
// ras_top, ras_valid and ras_ovf are tied to 0 and ras_push/ras_pop are
// ignored.
//
// Ports
//   clk, rst_n        clock (posedge), asynchronous active-low reset
//   stall, branch, jump, exc_req, eret
//                     per-cycle PC control requests
//   ras_push, ras_pop return-address-stack requests
//   offset            branch offset
//   jump_addr         jump target
//   epc               exception return address
//   ras_push_data     link address to push
//   pc                registered fetch address
//   fetch_err         pc misaligned or outside the legal fetch range
//   ras_top           predicted return address (0 when the stack is empty)
//   ras_valid         stack is non-empty
//   ras_ovf           sticky flag: a push overwrote an entry
// ---------------------------------------------------------------------------
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(32'h0000_6FFC),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch,
  input  logic             jump,
  input  logic             exc_req,
  input  logic             eret,
  input  logic             ras_push,
  input  logic             ras_pop,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic [WIDTH-1:0] epc,
  input  logic [WIDTH-1:0] ras_push_data,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_err,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_valid,
  output logic             ras_ovf
);

  // -------------------------------------------------------------------------
  // PC sequencing
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_next;

  // NOTE: combinational blocks assign a default first, so no path can leave
  // pc_next unassigned and infer a latch.
  always_comb begin
    pc_next = pc + WIDTH'(4);
    if (exc_req)     pc_next = EXC_VEC;
    else if (eret)   pc_next = epc;
    else if (stall)  pc_next = pc;
    else if (branch) pc_next = pc + offset;
    else if (jump)   pc_next = jump_addr;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_VEC;
    else        pc <= pc_next;
  end

  assign fetch_err = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);

`ifdef PC_GEN_RAS_EN
  // -------------------------------------------------------------------------
  // Return-address stack: circular buffer, top_q indexes the newest entry
  // -------------------------------------------------------------------------
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             ras_en;
  logic             do_push;
  logic             do_pop;
  logic             do_replace;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  // The pointer wraps explicitly, so RAS_DEPTH need not be a power of two.
  assign top_inc = (top_q == PTR_LAST) ? '0 : top_q + PTR_W'(1);
  assign top_dec = (top_q == '0) ? PTR_LAST : top_q - PTR_W'(1);

  // A stall freezes the stack unless an exception flushes the stall.
  assign ras_en = !stall || exc_req;

  // Push and pop in the same cycle replace the top entry. On an empty stack
  // the pop has nothing to cancel, so the pair behaves as a plain push.
  assign do_push    = ras_en && ras_push && (!ras_pop || count_q == '0);
  assign do_replace = ras_en && ras_push && ras_pop && count_q != '0;
  assign do_pop     = ras_en && ras_pop && !ras_push && count_q != '0;

  assign wr_en  = do_push || do_replace;
  assign wr_idx = do_push ? top_inc : top_q;

  // NOTE: the entry storage has no reset; count_q == 0 already marks every
  // entry invalid. The write is gated by rst_n so that an edge arriving
  // during reset does not leave a partial update behind.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) ras_mem[wr_idx] <= ras_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (do_push) begin
      // When the stack is full, top_inc lands on the oldest entry, so the
      // push overwrites it.
      top_q <= top_inc;
      if (count_q == CNT_MAX) ovf_q   <= 1'b1;
      else                    count_q <= count_q + CNT_W'(1);
    end else if (do_pop) begin
      top_q   <= top_dec;
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign ras_valid = (count_q != '0);
  assign ras_top   = ras_valid ? ras_mem[top_q] : '0;
  assign ras_ovf   = ovf_q;
`else
  // With the stack compiled out, its request inputs are ignored.
  logic unused_ras;
  assign unused_ras = ^{ras_push, ras_pop, ras_push_data};

  assign ras_top   = '0;
  assign ras_valid = 1'b0;
  assign ras_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- directed self-checking bench for pc_gen (default parameters).
// Inputs change 1 ns after each rising edge, and outputs are sampled at the
// same point, so every step() covers exactly one PC update.
// ---------------------------------------------------------------------------
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        stall, branch, jump, exc_req, eret, ras_push, ras_pop;
  logic [31:0] offset, jump_addr, epc, ras_push_data;
  logic [31:0] pc, ras_top;
  logic        fetch_err, ras_valid, ras_ovf;

  int n_checks = 0;
  int n_errors = 0;

  pc_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch        (branch),
    .jump          (jump),
    .exc_req       (exc_req),
    .eret          (eret),
    .ras_push      (ras_push),
    .ras_pop       (ras_pop),
    .offset        (offset),
    .jump_addr     (jump_addr),
    .epc           (epc),
    .ras_push_data (ras_push_data),
    .pc            (pc),
    .fetch_err     (fetch_err),
    .ras_top       (ras_top),
    .ras_valid     (ras_valid),
    .ras_ovf       (ras_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; branch = 0; jump = 0; exc_req = 0; eret = 0;
    ras_push = 0; ras_pop = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef PC_GEN_RAS_EN
  logic [31:0] push_vals [5] = '{32'hA0, 32'hA4, 32'hA8, 32'hAC, 32'hB0};
  logic [31:0] pop_tops  [3] = '{32'hAC, 32'hA8, 32'hA4};
`endif

  initial begin
    idle();
    offset = '0; jump_addr = '0; epc = '0; ras_push_data = '0;
    rst_n = 1'b0;
    #12;
    check("rst_pc", pc, 32'h3000);
    check("rst_err", {31'b0, fetch_err}, 32'h0);
    check("rst_valid", {31'b0, ras_valid}, 32'h0);
    check("rst_top", ras_top, 32'h0);
    check("rst_ovf", {31'b0, ras_ovf}, 32'h0);

    // Reset release followed by sequential fetch.
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_pc", pc, 32'h3000);
    step(); check("seq_3004", pc, 32'h3004);
    step(); check("seq_3008", pc, 32'h3008);
    step(); check("seq_300c", pc, 32'h300C);
    check("seq_err", {31'b0, fetch_err}, 32'h0);
    step(); check("seq_3010", pc, 32'h3010);

    // A branch wins over a jump; a negative offset wraps.
    branch = 1; offset = 32'hFFFF_FFF0; jump = 1; jump_addr = 32'h5000;
    step(); check("br_over_jump", pc, 32'h3000);
    idle();
    stall = 1; exc_req = 1;
    step(); check("exc_over_stall", pc, 32'h4180);
    exc_req = 0;
    step(); check("stall_hold", pc, 32'h4180);
    eret = 1; epc = 32'h3024;
    step(); check("eret_over_stall", pc, 32'h3024);
    idle();

    // fetch_err decode and its range boundaries.
    jump = 1; jump_addr = 32'h3002;
    step(); check("misalign_pc", pc, 32'h3002);
    check("misalign_err", {31'b0, fetch_err}, 32'h1);
    jump_addr = 32'h7000;
    step(); check("above_hi_err", {31'b0, fetch_err}, 32'h1);
    jump_addr = 32'h6FFC;
    step(); check("at_hi_err", {31'b0, fetch_err}, 32'h0);
    jump = 0;
    step(); check("err_no_effect_pc", pc, 32'h7000);
    check("err_no_effect_err", {31'b0, fetch_err}, 32'h1);
    jump = 1; jump_addr = 32'h2FFC;
    step(); check("below_lo_err", {31'b0, fetch_err}, 32'h1);
    jump_addr = 32'h3000;
    step(); check("at_lo_err", {31'b0, fetch_err}, 32'h0);
    jump_addr = 32'hFFFF_FFFC;
    step(); jump = 0;
    step(); check("wrap_pc", pc, 32'h0);
    check("wrap_err", {31'b0, fetch_err}, 32'h1);

    // Priority among exc_req, eret and branch.
    exc_req = 1; eret = 1; branch = 1; epc = 32'h3100; offset = 32'h8;
    step(); check("exc_over_eret", pc, 32'h4180);
    exc_req = 0;
    step(); check("eret_over_branch", pc, 32'h3100);
    eret = 0; stall = 1;
    step(); check("stall_over_branch", pc, 32'h3100);
    stall = 0;
    step(); check("branch_fwd", pc, 32'h3108);
    idle();

`ifdef PC_GEN_RAS_EN
    // Five pushes into a four-entry stack: the oldest entry is overwritten.
    ras_push = 1;
    for (int i = 0; i < 5; i++) begin
      ras_push_data = push_vals[i];
      step();
      check($sformatf("push%0d_top", i), ras_top, push_vals[i]);
      check($sformatf("push%0d_ovf", i), {31'b0, ras_ovf}, (i == 4) ? 32'h1 : 32'h0);
    end
    ras_push = 0; ras_pop = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("pop%0d_top", i), ras_top, pop_tops[i]);
    end
    step(); check("pop3_valid", {31'b0, ras_valid}, 32'h0);
    check("pop3_top", ras_top, 32'h0);
    step(); check("pop_empty_valid", {31'b0, ras_valid}, 32'h0);
    check("pop_empty_ovf", {31'b0, ras_ovf}, 32'h1);
    ras_pop = 0;

    // A push and a pop in the same cycle replace the top entry.
    ras_push = 1; ras_push_data = 32'h10;
    step(); check("push10_top", ras_top, 32'h10);
    ras_pop = 1; ras_push_data = 32'h20;
    step(); check("pushpop_top", ras_top, 32'h20);
    ras_push = 0;
    step(); check("pushpop_count1", {31'b0, ras_valid}, 32'h0);
    ras_pop = 0;
    stall = 1; ras_push = 1; ras_push_data = 32'h55;
    step(); check("stall_push_ignored", {31'b0, ras_valid}, 32'h0);
    exc_req = 1; ras_push_data = 32'h66;
    step(); check("exc_push_top", ras_top, 32'h66);
    check("exc_push_pc", pc, 32'h4180);
    idle();
`else
    // With the stack compiled out, its outputs stay 0 whatever is requested.
    ras_push = 1; ras_push_data = 32'hA0;
    step(); check("noras_top", ras_top, 32'h0);
    check("noras_valid", {31'b0, ras_valid}, 32'h0);
    ras_pop = 1;
    step(); check("noras_ovf", {31'b0, ras_ovf}, 32'h0);
    check("noras_pc", pc, 32'h3110);
    idle();
`endif

    // Reset asserted between clock edges takes effect at once.
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h3000);
    check("async_rst_valid", {31'b0, ras_valid}, 32'h0);
    check("async_rst_top", ras_top, 32'h0);
    check("async_rst_ovf", {31'b0, ras_ovf}, 32'h0);
    step(); check("rst_hold_pc", pc, 32'h3000);
    @(negedge clk);
    rst_n = 1'b1;
    step(); check("post_rst_pc", pc, 32'h3004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
